// File: rtl/m_axi_lite_pkg.sv
// m_axi_lite_pkg: state encoding and AXI response/protection constants shared by the
// AXI4-Lite master engine.
package m_axi_lite_pkg;
    typedef enum logic [2:0] {IDLE, WR, WR_RESP, RD_ADDR, RD_DATA, RSP} state_t;
    localparam logic [1:0] RESP_OKAY    = 2'b00;
    localparam logic [1:0] RESP_EXOKAY  = 2'b01;
    localparam logic [1:0] RESP_SLVERR  = 2'b10;
    localparam logic [1:0] RESP_DECERR  = 2'b11;
    localparam logic [2:0] PROT_DEFAULT = 3'b000;
endpackage

// File: rtl/m_axi_lite_watchdog.sv
// m_axi_lite_watchdog: counts cycles spent in one waiting state and flags expiry
// once the count reaches P_TIMEOUT_CYCLES-1.
module m_axi_lite_watchdog #(
    parameter int P_TIMEOUT_CYCLES = 256
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_active,
    input  logic i_restart,
    output logic o_expired
);
    localparam int LP_W = $clog2(P_TIMEOUT_CYCLES + 1);
    logic [LP_W-1:0] r_cnt;
    assign o_expired = i_active && (r_cnt == LP_W'(P_TIMEOUT_CYCLES - 1));
    always_ff @(posedge i_clk) begin
        if (i_rst || !i_active || i_restart)
            r_cnt <= '0;
        else if (!o_expired)
            r_cnt <= r_cnt + 1'b1;
    end
endmodule

// File: rtl/m_axi_lite_master.sv
// m_axi_lite_master: single-outstanding AXI4-Lite master fed by a valid/ready command port.
// Define M_AXI_LITE_TIMEOUT_EN to build the watchdog abort path.
module m_axi_lite_master
    import m_axi_lite_pkg::*;
#(
    parameter int P_ADDR_WIDTH     = 32,
    parameter int P_DATA_WIDTH     = 32,
    parameter int P_TIMEOUT_CYCLES = 256
) (
    input  logic                      M_AXI_ACLK,
    input  logic                      M_AXI_ARESET,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic                      cmd_write,
    input  logic [P_ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [P_DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [P_DATA_WIDTH/8-1:0] cmd_wstrb,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic                      rsp_write,
    output logic [P_DATA_WIDTH-1:0]   rsp_rdata,
    output logic [1:0]                rsp_resp,
    output logic                      rsp_timeout,
    output logic                      busy,
    output logic [P_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
    output logic [2:0]                M_AXI_AWPROT,
    output logic                      M_AXI_AWVALID,
    input  logic                      M_AXI_AWREADY,
    output logic [P_DATA_WIDTH-1:0]   M_AXI_WDATA,
    output logic [P_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
    output logic                      M_AXI_WVALID,
    input  logic                      M_AXI_WREADY,
    input  logic [1:0]                M_AXI_BRESP,
    input  logic                      M_AXI_BVALID,
    output logic                      M_AXI_BREADY,
    output logic [P_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
    output logic [2:0]                M_AXI_ARPROT,
    output logic                      M_AXI_ARVALID,
    input  logic                      M_AXI_ARREADY,
    input  logic [P_DATA_WIDTH-1:0]   M_AXI_RDATA,
    input  logic [1:0]                M_AXI_RRESP,
    input  logic                      M_AXI_RVALID,
    output logic                      M_AXI_RREADY
);
    state_t                    r_state;
    logic                      r_cmd_ready, r_write;
    logic [P_ADDR_WIDTH-1:0]   r_addr;
    logic [P_DATA_WIDTH-1:0]   r_wdata, r_rsp_rdata;
    logic [P_DATA_WIDTH/8-1:0] r_wstrb;
    logic                      r_awvalid, r_wvalid, r_bready, r_arvalid, r_rready;
    logic                      r_rsp_valid, r_rsp_write, r_rsp_timeout;
    logic [1:0]                r_rsp_resp;
    logic                      w_wr_done, w_step, w_expired;

    // The write phase is done once each channel has either already retired or retires now.
    assign w_wr_done = (!r_awvalid || M_AXI_AWREADY) && (!r_wvalid || M_AXI_WREADY);
    assign w_step = (r_state == WR)      ? w_wr_done :
                    (r_state == WR_RESP) ? M_AXI_BVALID :
                    (r_state == RD_ADDR) ? M_AXI_ARREADY :
                    (r_state == RD_DATA) ? M_AXI_RVALID : 1'b0;

`ifdef M_AXI_LITE_TIMEOUT_EN
    logic w_waiting;
    assign w_waiting = (r_state == WR) || (r_state == WR_RESP) ||
                       (r_state == RD_ADDR) || (r_state == RD_DATA);
    m_axi_lite_watchdog #(.P_TIMEOUT_CYCLES(P_TIMEOUT_CYCLES)) u_watchdog (
        .i_clk     (M_AXI_ACLK),
        .i_rst     (M_AXI_ARESET),
        .i_active  (w_waiting),
        .i_restart (w_step),
        .o_expired (w_expired)
    );
`else
    assign w_expired = 1'b0;
`endif

    always_ff @(posedge M_AXI_ACLK) begin
        if (M_AXI_ARESET) begin
            r_state       <= IDLE;
            r_cmd_ready   <= 1'b0;
            r_write       <= 1'b0;
            r_addr        <= '0;
            r_wdata       <= '0;
            r_wstrb       <= '0;
            r_awvalid     <= 1'b0;
            r_wvalid      <= 1'b0;
            r_bready      <= 1'b0;
            r_arvalid     <= 1'b0;
            r_rready      <= 1'b0;
            r_rsp_valid   <= 1'b0;
            r_rsp_write   <= 1'b0;
            r_rsp_rdata   <= '0;
            r_rsp_resp    <= RESP_OKAY;
            r_rsp_timeout <= 1'b0;
        end else if (w_expired && !w_step) begin
            // Debug recovery: drop every handshake signal and report a synthetic SLVERR.
            r_awvalid     <= 1'b0;
            r_wvalid      <= 1'b0;
            r_bready      <= 1'b0;
            r_arvalid     <= 1'b0;
            r_rready      <= 1'b0;
            r_rsp_valid   <= 1'b1;
            r_rsp_write   <= r_write;
            r_rsp_rdata   <= '0;
            r_rsp_resp    <= RESP_SLVERR;
            r_rsp_timeout <= 1'b1;
            r_state       <= RSP;
        end else begin
            case (r_state)
                IDLE: begin
                    if (cmd_valid && r_cmd_ready) begin
                        r_cmd_ready <= 1'b0;
                        r_write     <= cmd_write;
                        r_addr      <= cmd_addr;
                        r_wdata     <= cmd_wdata;
                        r_wstrb     <= cmd_wstrb;
                        r_awvalid   <= cmd_write;
                        r_wvalid    <= cmd_write;
                        r_arvalid   <= !cmd_write;
                        r_state     <= cmd_write ? WR : RD_ADDR;
                    end else begin
                        r_cmd_ready <= 1'b1;
                    end
                end
                WR: begin
                    if (M_AXI_AWREADY) r_awvalid <= 1'b0;
                    if (M_AXI_WREADY) r_wvalid <= 1'b0;
                    if (w_step) begin
                        r_bready <= 1'b1;
                        r_state  <= WR_RESP;
                    end
                end
                WR_RESP: begin
                    if (w_step) begin
                        r_bready      <= 1'b0;
                        r_rsp_valid   <= 1'b1;
                        r_rsp_write   <= 1'b1;
                        r_rsp_rdata   <= '0;
                        r_rsp_resp    <= M_AXI_BRESP;
                        r_rsp_timeout <= 1'b0;
                        r_state       <= RSP;
                    end
                end
                RD_ADDR: begin
                    if (w_step) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                        r_state   <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    if (w_step) begin
                        r_rready      <= 1'b0;
                        r_rsp_valid   <= 1'b1;
                        r_rsp_write   <= 1'b0;
                        r_rsp_rdata   <= M_AXI_RDATA;
                        r_rsp_resp    <= M_AXI_RRESP;
                        r_rsp_timeout <= 1'b0;
                        r_state       <= RSP;
                    end
                end
                RSP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_cmd_ready <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign cmd_ready     = r_cmd_ready;
    assign busy          = (r_state != IDLE);
    assign rsp_valid     = r_rsp_valid;
    assign rsp_write     = r_rsp_write;
    assign rsp_rdata     = r_rsp_rdata;
    assign rsp_resp      = r_rsp_resp;
    assign rsp_timeout   = r_rsp_timeout;
    assign M_AXI_AWADDR  = r_addr;
    assign M_AXI_AWPROT  = PROT_DEFAULT;
    assign M_AXI_AWVALID = r_awvalid;
    assign M_AXI_WDATA   = r_wdata;
    assign M_AXI_WSTRB   = r_wstrb;
    assign M_AXI_WVALID  = r_wvalid;
    assign M_AXI_BREADY  = r_bready;
    assign M_AXI_ARADDR  = r_addr;
    assign M_AXI_ARPROT  = PROT_DEFAULT;
    assign M_AXI_ARVALID = r_arvalid;
    assign M_AXI_RREADY  = r_rready;
endmodule

// File: tb/tb_m_axi_lite_master.sv
// tb_m_axi_lite_master: directed bench with a small AXI4-Lite memory slave.
// Covers both builds of M_AXI_LITE_TIMEOUT_EN.
`timescale 1ns/1ps
module tb_m_axi_lite_master;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    always #5 clk = ~clk;

    logic        cmd_valid = 1'b0, cmd_write = 1'b0, rsp_ready = 1'b1;
    logic [31:0] cmd_addr = '0, cmd_wdata = '0;
    logic [3:0]  cmd_wstrb = '0;
    logic        cmd_ready, rsp_valid, rsp_write, rsp_timeout, busy;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [2:0]  awprot, arprot;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;

    int          cfg_aw_delay = 0;
    logic [1:0]  cfg_bresp = 2'b00;
    logic        cfg_b_block = 1'b0, cfg_ar_block = 1'b0;
    int          errors = 0, checks = 0;

    m_axi_lite_master #(.P_ADDR_WIDTH(32), .P_DATA_WIDTH(32), .P_TIMEOUT_CYCLES(16)) dut (
        .M_AXI_ACLK(clk), .M_AXI_ARESET(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
        .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout), .busy(busy),
        .M_AXI_AWADDR(awaddr), .M_AXI_AWPROT(awprot), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
        .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
        .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
        .M_AXI_ARADDR(araddr), .M_AXI_ARPROT(arprot), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
        .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready)
    );

    // Memory slave: AWREADY after cfg_aw_delay waiting cycles, WREADY immediate.
    logic [31:0] mem [16];
    int          aw_wait;
    logic        s_aw_got, s_w_got, aw_hs, w_hs, aw_n, w_n;
    logic [31:0] s_addr, s_data, a_n, d_n;
    logic [3:0]  s_strb, strb_n;
    assign awready = awvalid && (aw_wait >= cfg_aw_delay);
    assign wready  = wvalid;
    assign arready = arvalid && !cfg_ar_block;
    assign aw_hs   = awvalid && awready;
    assign w_hs    = wvalid && wready;
    assign aw_n    = s_aw_got || aw_hs;
    assign w_n     = s_w_got || w_hs;
    assign a_n     = aw_hs ? awaddr : s_addr;
    assign d_n     = w_hs ? wdata : s_data;
    assign strb_n  = w_hs ? wstrb : s_strb;

    initial for (int i = 0; i < 16; i++) mem[i] = '0;

    always @(posedge clk) begin
        if (rst) begin
            aw_wait  <= 0;
            s_aw_got <= 1'b0;
            s_w_got  <= 1'b0;
            s_addr   <= '0;
            s_data   <= '0;
            s_strb   <= '0;
            bvalid   <= 1'b0;
            bresp    <= 2'b00;
            rvalid   <= 1'b0;
            rdata    <= '0;
            rresp    <= 2'b00;
        end else begin
            aw_wait <= aw_hs ? 0 : (awvalid ? aw_wait + 1 : 0);
            s_addr  <= a_n;
            s_data  <= d_n;
            s_strb  <= strb_n;
            if (bvalid && bready) bvalid <= 1'b0;
            if (aw_n && w_n) begin
                s_aw_got <= 1'b0;
                s_w_got  <= 1'b0;
                for (int b = 0; b < 4; b++)
                    if (strb_n[b]) mem[a_n[5:2]][8*b +: 8] <= d_n[8*b +: 8];
                if (!cfg_b_block) begin
                    bvalid <= 1'b1;
                    bresp  <= cfg_bresp;
                end
            end else begin
                s_aw_got <= aw_n;
                s_w_got  <= w_n;
            end
            if (rvalid && rready) rvalid <= 1'b0;
            if (arvalid && arready) begin
                rvalid <= 1'b1;
                rdata  <= mem[araddr[5:2]];
                rresp  <= 2'b00;
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic zero_chk(input string tag);
        chk({tag, "_ctl"}, {cmd_ready, rsp_valid, rsp_write, rsp_resp, rsp_timeout, busy,
                            awvalid, wvalid, bready, arvalid, rready}, '0);
        chk({tag, "_addr"}, {awaddr, wdata}, '0);
        chk({tag, "_data"}, {rsp_rdata, araddr[23:0], wstrb, awprot, arprot}, '0);
    endtask

    task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        int n = 0;
        while (!cmd_ready && n < 20) begin
            tick();
            n++;
        end
        chk("cmd_ready_wait", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
        cmd_wstrb = s;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int lat);
        lat = 1;
        while (!rsp_valid && lat < 100) begin
            tick();
            lat++;
        end
        chk("rsp_seen", rsp_valid, 1);
    endtask

    initial begin
        int   lat, n, aw_cyc, w_cyc, b_first, ar_cyc;
        logic bad;
        repeat (3) tick();
        zero_chk("reset");
        rst = 1'b0;
        tick();
        chk("ready_after_reset", cmd_ready, 1);

        // Write then read back, AW and W together.
        issue(1'b1, 32'h4, 32'hDEADBEEF, 4'hF);
        chk("t1_aw_w_same_cycle", {awvalid, wvalid}, 2'b11);
        chk("t1_aw_payload", {awaddr, wstrb}, {32'h4, 4'hF});
        chk("t1_wdata", wdata, 32'hDEADBEEF);
        wait_rsp(lat);
        chk("t1_wr_latency", lat, 3);
        chk("t1_wr_rsp", {rsp_write, rsp_resp, rsp_timeout, rsp_rdata}, {1'b1, 2'b00, 1'b0, 32'h0});
        tick();
        chk("t1_idle", {rsp_valid, cmd_ready, busy}, 3'b010);
        issue(1'b0, 32'h4, 32'h0, 4'h0);
        chk("t1_ar", {arvalid, araddr}, {1'b1, 32'h4});
        wait_rsp(lat);
        chk("t1_rd_latency", lat, 3);
        chk("t1_rd_rsp", {rsp_write, rsp_resp, rsp_timeout, rsp_rdata}, {1'b0, 2'b00, 1'b0, 32'hDEADBEEF});
        tick();

        // Skewed slave: AWREADY waits 3 cycles.
        cfg_aw_delay = 3;
        issue(1'b1, 32'h8, 32'h11223344, 4'hF);
        aw_cyc = 0; w_cyc = 0; b_first = 0; bad = 1'b0; n = 1;
        while (!rsp_valid && n < 50) begin
            if (awvalid) begin
                aw_cyc++;
                if (awaddr !== 32'h8) bad = 1'b1;
            end
            if (wvalid) w_cyc++;
            if (bready && b_first == 0) b_first = n;
            tick();
            n++;
        end
        chk("t2_aw_cycles", aw_cyc, 4);
        chk("t2_w_cycles", w_cyc, 1);
        chk("t2_awaddr_stable", bad, 0);
        chk("t2_bready_first", b_first, 5);
        chk("t2_latency", n, 6);
        cfg_aw_delay = 0;
        tick();

        // Response backpressure on a read.
        issue(1'b1, 32'h10, 32'h12345678, 4'hF);
        wait_rsp(lat);
        tick();
        rsp_ready = 1'b0;
        issue(1'b0, 32'h10, 32'h0, 4'h0);
        wait_rsp(lat);
        chk("t3_latency", lat, 3);
        bad = 1'b0;
        repeat (5) begin
            if (!rsp_valid || rsp_rdata !== 32'h12345678 || cmd_ready || !busy) bad = 1'b1;
            tick();
        end
        chk("t3_held_stable", bad, 0);
        chk("t3_still_held", {rsp_valid, cmd_ready, busy, rsp_rdata}, {3'b101, 32'h12345678});
        rsp_ready = 1'b1;
        tick();
        chk("t3_released", {rsp_valid, cmd_ready, busy}, 3'b010);

        // SLVERR write with partial strobes, then read back the merged word.
        issue(1'b1, 32'h20, 32'hAABBCCDD, 4'hF);
        wait_rsp(lat);
        tick();
        cfg_bresp = 2'b10;
        issue(1'b1, 32'h20, 32'h11112222, 4'b0011);
        chk("t4_wstrb", wstrb, 4'b0011);
        wait_rsp(lat);
        chk("t4_err_rsp", {rsp_write, rsp_resp, rsp_timeout}, {1'b1, 2'b10, 1'b0});
        tick();
        cfg_bresp = 2'b00;
        chk("t4_back_idle", {cmd_ready, busy}, 2'b10);
        issue(1'b0, 32'h20, 32'h0, 4'h0);
        wait_rsp(lat);
        chk("t4_readback", {rsp_resp, rsp_rdata}, {2'b00, 32'hAABB2222});
        tick();

        // Reset while waiting in WR_RESP.
        cfg_b_block = 1'b1;
        issue(1'b1, 32'h30, 32'hCAFEF00D, 4'hF);
        n = 0;
        while (!bready && n < 20) begin
            tick();
            n++;
        end
        chk("t5_in_wr_resp", {bready, busy}, 2'b11);
        rst = 1'b1;
        tick();
        zero_chk("t5_mid_reset");
        rst = 1'b0;
        cfg_b_block = 1'b0;
        bad = 1'b0;
        repeat (3) begin
            if (rsp_valid) bad = 1'b1;
            tick();
        end
        chk("t5_no_rsp", bad, 0);
        issue(1'b0, 32'h4, 32'h0, 4'h0);
        wait_rsp(lat);
        chk("t5_read_latency", lat, 3);
        chk("t5_read", {rsp_resp, rsp_rdata}, {2'b00, 32'hDEADBEEF});
        tick();

        // Slave never accepts AR.
        cfg_ar_block = 1'b1;
        issue(1'b0, 32'h4, 32'h0, 4'h0);
        ar_cyc = 0;
`ifdef M_AXI_LITE_TIMEOUT_EN
        n = 1;
        while (!rsp_valid && n < 60) begin
            if (arvalid) ar_cyc++;
            tick();
            n++;
        end
        chk("t6_ar_cycles", ar_cyc, 16);
        chk("t6_abort_latency", n, 17);
        chk("t6_abort_rsp", {rsp_valid, rsp_write, rsp_resp, rsp_timeout, arvalid, rready},
            {1'b1, 1'b0, 2'b10, 1'b1, 1'b0, 1'b0});
        tick();
        cfg_ar_block = 1'b0;
        chk("t6_back_idle", {cmd_ready, busy}, 2'b10);
`else
        repeat (40) begin
            if (arvalid) ar_cyc++;
            tick();
        end
        chk("t6_ar_held", ar_cyc, 40);
        chk("t6_still_waiting", {arvalid, rsp_valid, busy}, 3'b101);
        cfg_ar_block = 1'b0;
        wait_rsp(lat);
        chk("t6_late_read", {rsp_resp, rsp_timeout, rsp_rdata}, {2'b00, 1'b0, 32'hDEADBEEF});
        tick();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end
endmodule
